// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between n_req requesters.
// Requests are granted round-robin and issued to the ALU with a one-cycle
// registered strobe. The index of each issuing requester goes into an
// in-order tag FIFO. Each ALU result pops that FIFO and is routed back to
// the requester that issued it.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clr                synchronous flush (err_o is kept)
//   req_valid_i/ready  per-requester handshake (ready is combinational)
//   req_op/key/A/B_i   packed per-requester payload, requester i in slice i
//   rsp_valid/key/O_o  per-requester result strobe and held result
//   alu_*_o            issue side towards the ALU
//   alu_valid/key/O_i  in-order result side from the ALU
//   busy_o             tag FIFO non-empty
//   err_o              sticky: ALU result arrived with no outstanding tag
// max_out must be a power of two, at least 2.
module alu_arbiter #(
  parameter int unsigned n_req     = 2,
  parameter int unsigned op_bits   = 8,
  parameter int unsigned key_bits  = 8,
  parameter int unsigned data_bits = 32,
  parameter int unsigned max_out   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [n_req-1:0]             req_valid_i,
  output logic [n_req-1:0]             req_ready_o,
  input  logic [n_req*op_bits-1:0]     req_op_i,
  input  logic [n_req*key_bits-1:0]    req_key_i,
  input  logic [n_req*data_bits-1:0]   req_A_i,
  input  logic [n_req*data_bits-1:0]   req_B_i,
  output logic [n_req-1:0]             rsp_valid_o,
  output logic [n_req*key_bits-1:0]    rsp_key_o,
  output logic [n_req*data_bits-1:0]   rsp_O_o,
  output logic                         alu_valid_o,
  output logic [op_bits-1:0]           alu_op_o,
  output logic [key_bits-1:0]          alu_key_o,
  output logic [data_bits-1:0]         alu_A_o,
  output logic [data_bits-1:0]         alu_B_o,
  input  logic                         alu_valid_i,
  input  logic [key_bits-1:0]          alu_key_i,
  input  logic [data_bits-1:0]         alu_O_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned idx_bits = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int unsigned ptr_bits = (max_out > 1) ? $clog2(max_out) : 1;
  localparam int unsigned cnt_bits = $clog2(max_out + 1);
  localparam logic [idx_bits-1:0] last_idx = idx_bits'(n_req - 1);
  localparam logic [cnt_bits-1:0] full_cnt = cnt_bits'(max_out);

  logic [idx_bits-1:0]        r_last_grant;
  logic [idx_bits-1:0]        r_tag [max_out];
  logic [ptr_bits-1:0]        r_wr_ptr;
  logic [ptr_bits-1:0]        r_rd_ptr;
  logic [cnt_bits-1:0]        r_count;
  logic                       r_alu_valid;
  logic [op_bits-1:0]         r_alu_op;
  logic [key_bits-1:0]        r_alu_key;
  logic [data_bits-1:0]       r_alu_A;
  logic [data_bits-1:0]       r_alu_B;
  logic [n_req-1:0]           r_rsp_valid;
  logic [n_req*key_bits-1:0]  r_rsp_key;
  logic [n_req*data_bits-1:0] r_rsp_O;
  logic                       r_busy;
  logic                       r_err;

  logic [n_req-1:0]    w_grant_vec;
  logic [idx_bits-1:0] w_grant_idx;
  logic [idx_bits-1:0] w_cand;
  logic                w_grant_any;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic [idx_bits-1:0] w_head;
  logic [cnt_bits-1:0] w_count_nxt;

  // Round-robin scan starting just after the last grant; gated by the registered count.
  always_comb begin
    w_grant_vec = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    w_cand      = '0;
    if (r_count < full_cnt) begin
      for (int unsigned k = 1; k <= n_req; k++) begin
        w_cand = idx_bits'((32'(r_last_grant) + k) % n_req);
        if (!w_grant_any && req_valid_i[w_cand]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
    if (w_grant_any) begin
      w_grant_vec[w_grant_idx] = 1'b1;
    end
  end

  assign req_ready_o = w_grant_vec;
  assign w_push      = w_grant_any;
  assign w_pop       = alu_valid_i && (r_count != '0);
  assign w_drop      = alu_valid_i && (r_count == '0);
  assign w_head      = r_tag[r_rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + cnt_bits'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - cnt_bits'(1);
    end
  end

  // Tag storage; contents are meaningless while the FIFO is empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !clr) begin
      r_tag[r_wr_ptr] <= w_grant_idx;
    end
  end

  // Issue, response routing and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_last_grant <= last_idx;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_alu_valid  <= 1'b0;
      r_alu_op     <= '0;
      r_alu_key    <= '0;
      r_alu_A      <= '0;
      r_alu_B      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_key    <= '0;
      r_rsp_O      <= '0;
      r_busy       <= 1'b0;
      if (rst) begin
        r_err <= 1'b0;
      end
    end else begin
      r_alu_valid <= w_push;
      if (w_push) begin
        r_alu_op     <= req_op_i[w_grant_idx*op_bits +: op_bits];
        r_alu_key    <= req_key_i[w_grant_idx*key_bits +: key_bits];
        r_alu_A      <= req_A_i[w_grant_idx*data_bits +: data_bits];
        r_alu_B      <= req_B_i[w_grant_idx*data_bits +: data_bits];
        r_last_grant <= w_grant_idx;
        r_wr_ptr     <= r_wr_ptr + 1'b1;
      end
      r_rsp_valid <= '0;
      if (w_pop) begin
        r_rsp_valid[w_head]                        <= 1'b1;
        r_rsp_key[w_head*key_bits +: key_bits]     <= alu_key_i;
        r_rsp_O[w_head*data_bits +: data_bits]     <= alu_O_i;
        r_rd_ptr                                   <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);
    end
  end

  assign alu_valid_o = r_alu_valid;
  assign alu_op_o    = r_alu_op;
  assign alu_key_o   = r_alu_key;
  assign alu_A_o     = r_alu_A;
  assign alu_B_o     = r_alu_B;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_key_o   = r_rsp_key;
  assign rsp_O_o     = r_rsp_O;
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios followed by randomized traffic,
// compared every cycle against a queue-based reference model and an
// in-order ALU model that returns A+B with a per-operation latency.
module tb_alu_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned OPB = 8;
  localparam int unsigned KB  = 8;
  localparam int unsigned DB  = 32;
  localparam int unsigned MO  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clr;
  logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o;
  logic [N*OPB-1:0] req_op_i;
  logic [N*KB-1:0] req_key_i, rsp_key_o;
  logic [N*DB-1:0] req_A_i, req_B_i, rsp_O_o;
  logic            alu_valid_o, alu_valid_i, busy_o, err_o;
  logic [OPB-1:0]  alu_op_o;
  logic [KB-1:0]   alu_key_o, alu_key_i;
  logic [DB-1:0]   alu_A_o, alu_B_o, alu_O_i;

  alu_arbiter #(.n_req(N), .op_bits(OPB), .key_bits(KB), .data_bits(DB), .max_out(MO)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_key_i(req_key_i), .req_A_i(req_A_i), .req_B_i(req_B_i),
    .rsp_valid_o(rsp_valid_o), .rsp_key_o(rsp_key_o), .rsp_O_o(rsp_O_o),
    .alu_valid_o(alu_valid_o), .alu_op_o(alu_op_o), .alu_key_o(alu_key_o),
    .alu_A_o(alu_A_o), .alu_B_o(alu_B_o),
    .alu_valid_i(alu_valid_i), .alu_key_i(alu_key_i), .alu_O_i(alu_O_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Requester side: each holds its request until it is consumed.
  logic          rv   [N];
  logic [OPB-1:0] rop [N];
  logic [KB-1:0] rkey [N];
  logic [DB-1:0] ra   [N];
  logic [DB-1:0] rb   [N];
  bit sticky, auto_mode, alu_stall;
  int lat_min, lat_max;

  // ALU model: in-order results, each released no earlier than its due cycle.
  typedef struct packed {
    logic [31:0]   due;
    logic [KB-1:0] key;
    logic [DB-1:0] o;
  } alu_item_t;
  alu_item_t alu_q[$];

  // Reference model state.
  int            m_last;
  int            m_q[$];
  logic          e_alu_valid;
  logic [OPB-1:0] e_op;
  logic [KB-1:0] e_key;
  logic [DB-1:0] e_a, e_b;
  logic [N-1:0]  e_rsp_valid;
  logic [N*KB-1:0] e_rsp_key;
  logic [N*DB-1:0] e_rsp_o;
  logic          e_busy, e_err;

  logic [N-1:0]  obs_ready;
  int            rsp_cnt [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input bit full);
    m_q.delete();
    m_last      = N - 1;
    e_alu_valid = 1'b0;
    e_op = '0; e_key = '0; e_a = '0; e_b = '0;
    e_rsp_valid = '0; e_rsp_key = '0; e_rsp_o = '0;
    e_busy = 1'b0;
    if (full) e_err = 1'b0;
  endtask

  // Requester that gets the next grant, or -1.
  function automatic int model_grant();
    if (m_q.size() >= MO) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid_i[i]) return i;
    end
    return -1;
  endfunction

  task automatic new_request(input int i);
    rv[i]   = 1'b1;
    rop[i]  = OPB'($urandom);
    rkey[i] = KB'($urandom);
    ra[i]   = $urandom;
    rb[i]   = $urandom;
  endtask

  task automatic model_update(input int g);
    int h;
    if (rst) begin
      model_reset(1'b1);
    end else if (clr) begin
      model_reset(1'b0);
    end else begin
      e_alu_valid = (g >= 0);
      if (g >= 0) begin
        e_op = rop[g]; e_key = rkey[g]; e_a = ra[g]; e_b = rb[g];
        m_last = g;
        alu_q.push_back('{due: 32'(cyc + 1 + $urandom_range(lat_min, lat_max)),
                          key: rkey[g], o: ra[g] + rb[g]});
      end
      e_rsp_valid = '0;
      if (alu_valid_i) begin
        if (m_q.size() > 0) begin
          h = m_q.pop_front();
          e_rsp_valid[h] = 1'b1;
          e_rsp_key[h*KB +: KB] = alu_key_i;
          e_rsp_o[h*DB +: DB]   = alu_O_i;
        end else begin
          e_err = 1'b1;
        end
      end
      if (g >= 0) m_q.push_back(g);
      e_busy = (m_q.size() != 0);
      if (g >= 0) begin
        if (sticky) begin
          ra[g] = $urandom;
          rb[g] = $urandom;
        end else begin
          rv[g] = 1'b0;
        end
      end
    end
    if (auto_mode) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 9) < 6) new_request(i);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  task automatic tick();
    int g;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]            = rv[i];
      req_op_i[i*OPB +: OPB]    = rop[i];
      req_key_i[i*KB +: KB]     = rkey[i];
      req_A_i[i*DB +: DB]       = ra[i];
      req_B_i[i*DB +: DB]       = rb[i];
    end
    if (!alu_stall && alu_q.size() > 0 && int'(alu_q[0].due) <= cyc) begin
      alu_valid_i = 1'b1;
      alu_key_i   = alu_q[0].key;
      alu_O_i     = alu_q[0].o;
      void'(alu_q.pop_front());
    end else begin
      alu_valid_i = 1'b0;
      alu_key_i   = KB'($urandom);
      alu_O_i     = $urandom;
    end
    @(negedge clk);
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready_o;
    for (int i = 0; i < N; i++) rsp_cnt[i] += int'(rsp_valid_o[i]);
    check("ready",     64'(req_ready_o), 64'(exp_ready));
    check("alu_valid", 64'(alu_valid_o), 64'(e_alu_valid));
    check("alu_op",    64'(alu_op_o),    64'(e_op));
    check("alu_key",   64'(alu_key_o),   64'(e_key));
    check("alu_A",     64'(alu_A_o),     64'(e_a));
    check("alu_B",     64'(alu_B_o),     64'(e_b));
    check("rsp_valid", 64'(rsp_valid_o), 64'(e_rsp_valid));
    check("rsp_key",   64'(rsp_key_o),   64'(e_rsp_key));
    check("rsp_O",     64'(rsp_O_o),     64'(e_rsp_o));
    check("busy",      64'(busy_o),      64'(e_busy));
    check("err",       64'(err_o),       64'(e_err));
    @(posedge clk);
    model_update(g);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
  endtask

  task automatic drain();
    clear_reqs();
    sticky = 0;
    alu_stall = 0;
    repeat (14) tick();
  endtask

  initial begin
    int gseq[$];
    int ngr;
    rst = 1'b1; clr = 1'b0;
    req_valid_i = '0; req_op_i = '0; req_key_i = '0; req_A_i = '0; req_B_i = '0;
    alu_valid_i = 1'b0; alu_key_i = '0; alu_O_i = '0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; rop[i] = '0; rkey[i] = '0; ra[i] = '0; rb[i] = '0; rsp_cnt[i] = 0;
    end
    sticky = 0; auto_mode = 0; alu_stall = 0; lat_min = 3; lat_max = 3;
    e_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset(1'b1);
    tick();
    rst = 1'b0;
    check("reset_state", 64'({alu_valid_o, busy_o, err_o, rsp_valid_o}), 64'(0));

    // Single request from requester 0: 5 + 7 comes back as 12.
    rv[0] = 1'b1; rop[0] = 8'h02; rkey[0] = 8'h11; ra[0] = 32'd5; rb[0] = 32'd7;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    tick();
    check("t1_ready", 64'(obs_ready), 64'(2'b01));
    check("t1_alu_valid", 64'(alu_valid_o), 64'(1));
    check("t1_alu_op", 64'(alu_op_o), 64'(8'h02));
    check("t1_alu_A", 64'(alu_A_o), 64'(5));
    check("t1_alu_B", 64'(alu_B_o), 64'(7));
    repeat (6) tick();
    check("t1_rsp_count", 64'(rsp_cnt[0]), 64'(1));
    check("t1_rsp_O", 64'(rsp_O_o[DB-1:0]), 64'(12));

    // Both requesters continuously valid: grants alternate from requester 0.
    do_reset();
    rv[0] = 1'b1; rop[0] = 8'h01; rkey[0] = 8'hA0; ra[0] = 32'd1; rb[0] = 32'd2;
    rv[1] = 1'b1; rop[1] = 8'h01; rkey[1] = 8'hB1; ra[1] = 32'd3; rb[1] = 32'd4;
    sticky = 1;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (obs_ready != '0) gseq.push_back(obs_ready[1] ? 1 : 0);
    end
    drain();
    check("t2_grants", 64'(gseq.size()), 64'(5));
    foreach (gseq[j]) check("t2_grant_order", 64'(gseq[j]), 64'(j % 2));
    check("t2_rsp_cnt0", 64'(rsp_cnt[0]), 64'(3));
    check("t2_rsp_cnt1", 64'(rsp_cnt[1]), 64'(2));
    check("t2_key0", 64'(rsp_key_o[KB-1:0]), 64'(8'hA0));
    check("t2_key1", 64'(rsp_key_o[2*KB-1:KB]), 64'(8'hB1));

    // Backpressure with the ALU stalled: exactly max_out grants.
    do_reset();
    alu_stall = 1; sticky = 1;
    new_request(0); new_request(1);
    ngr = 0;
    repeat (8) begin
      tick();
      if (obs_ready != '0) ngr++;
    end
    check("t3_grants", 64'(ngr), 64'(MO));
    check("t3_full_ready", 64'(obs_ready), 64'(0));
    alu_stall = 0;
    tick();
    check("t3_ready_at_pop", 64'(obs_ready), 64'(0));
    tick();
    check("t3_regrant", 64'(obs_ready != '0), 64'(1));
    drain();

    // Push and pop in the same cycle at count 2.
    do_reset();
    alu_stall = 1;
    new_request(0); new_request(1);
    repeat (6) tick();
    alu_stall = 0;
    new_request(1);
    tick();
    check("t4_ready", 64'(obs_ready), 64'(2'b10));
    check("t4_rsp_oldest", 64'(rsp_valid_o), 64'(2'b01));
    check("t4_busy", 64'(busy_o), 64'(1));
    drain();

    // Reset with three outstanding: late results are dropped and flag err_o.
    do_reset();
    alu_stall = 1;
    new_request(0); new_request(1);
    tick(); tick();
    new_request(0);
    tick();
    do_reset();
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    alu_stall = 0;
    repeat (8) tick();
    check("t5_no_rsp", 64'(rsp_cnt[0] + rsp_cnt[1]), 64'(0));
    check("t5_err", 64'(err_o), 64'(1));
    do_reset();
    check("t5_err_clr", 64'(err_o), 64'(0));

    // clr at count 2 restores requester 0 priority.
    alu_stall = 1;
    new_request(1);
    tick();
    new_request(0);
    tick();
    new_request(0); new_request(1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t6_busy", 64'(busy_o), 64'(0));
    tick();
    check("t6_grant", 64'(obs_ready), 64'(2'b01));
    tick();
    drain();
    check("t6_err_kept", 64'(err_o), 64'(1));
    do_reset();

    // Randomized traffic with stalls, flushes and resets.
    auto_mode = 1; lat_min = 1; lat_max = 5;
    repeat (2500) begin
      alu_stall = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      clr = 1'b0;
      rst = 1'b0;
    end
    auto_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single 32-bit ALU between n_req requesters, such as the left and right speed PIDs and later the position PIDs.
- Grants requests round-robin and forwards the op, key and operands to the ALU.
- Records the issuing requester in an in-order tag FIFO, then routes each ALU result back to the requester that issued it.
- Sits between the PID instances and the ALU in the motion-control top level. PID ports connect unchanged, plus a valid/ready pair per requester.

Parameters:
- n_req, 2, number of requesters (2..8).
- op_bits, 8, ALU opcode width.
- key_bits, 8, requester-supplied tag width, passed through the ALU.
- data_bits, 32, operand/result width.
- max_out, 4, maximum outstanding ALU operations (power of 2; tag FIFO depth).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous flush: empties the tag FIFO and resets the pointer; outputs behave as at reset.
- req_valid_i  in  n_req  per-requester request valid.
- req_ready_o  out  n_req  per-requester grant (one-hot or zero).
- req_op_i  in  n_req*op_bits  packed opcodes; requester i occupies slice i.
- req_key_i  in  n_req*key_bits  packed keys.
- req_A_i  in  n_req*data_bits  packed operand A.
- req_B_i  in  n_req*data_bits  packed operand B.
- rsp_valid_o  out  n_req  one-cycle result strobe per requester.
- rsp_key_o  out  n_req*key_bits  returned key, held until the next response to that requester.
- rsp_O_o  out  n_req*data_bits  returned result, held until the next response to that requester.
- alu_valid_o  out  1  issue strobe to the ALU.
- alu_op_o  out  op_bits  opcode to the ALU.
- alu_key_o  out  key_bits  key to the ALU.
- alu_A_o  out  data_bits  operand A to the ALU.
- alu_B_o  out  data_bits  operand B to the ALU.
- alu_valid_i  in  1  ALU result strobe; results return in issue order.
- alu_key_i  in  key_bits  ALU returned key.
- alu_O_i  in  data_bits  ALU result.
- busy_o  out  1  tag FIFO non-empty.
- err_o  out  1  sticky: ALU result arrived with the tag FIFO empty.

Behaviour:
- Reset/clr: all outputs 0, tag FIFO empty (count=0), last_grant=n_req-1, so requester 0 has priority first. err_o is cleared by rst only, not by clr.
- Arbitration:
  - Combinational within the cycle.
  - If count<max_out, scan i=last_grant+1 … last_grant+n_req (mod n_req) and grant the first i with req_valid_i[i]=1.
  - req_ready_o[i]=1 for the granted i only. A handshake happens when valid&ready.
  - No grant while count==max_out. "Full" uses the registered count, so a pop in the same cycle does not enable a push.
- Issue: on handshake at cycle t, register the requester's op/key/A/B onto the alu_* outputs and pulse alu_valid_o=1 at t+1.
  - alu_* data holds its last value when alu_valid_o=0.
  - Push index i into the FIFO and set last_grant=i.
  - Throughput is one issue per cycle.
- Requester rule: req_valid_i and the payload are held stable until ready; the arbiter does not latch ungranted requests.
- Response: on alu_valid_i at cycle r with FIFO non-empty, pop head index h. At r+1: rsp_valid_o[h]=1, rsp_key_o[h]=alu_key_i, rsp_O_o[h]=alu_O_i; other slices are unchanged.
- Empty FIFO at response: the response is dropped, err_o=1 from r+1, no rsp_valid.
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo max_out.
- Reset or clr mid-operation: outstanding tags are discarded. ALU results arriving afterwards hit an empty FIFO and set err_o.
- busy_o = (count != 0), registered.

Test Plan:
- Single request: req_valid_i=2'b01, op=8'h02, A=5, B=7. Expect ready[0] same cycle, alu_valid_o one cycle later with A=5, B=7. ALU model returns O=12 after 3 cycles, then rsp_valid_o[0] pulses once with rsp_O_o[0]=12.
- Both requesters valid continuously, 6 cycles, with a 3-cycle ALU:
  - Grants alternate 0,1,0,1… starting with 0.
  - Key 8'hA0 (req 0) and 8'hB1 (req 1) come back on the matching slices in issue order.
- Backpressure with max_out=4, ALU stalled: exactly 4 grants occur, ready stays 0 afterwards. The first returned result re-enables grants one cycle after the pop.
- Simultaneous push and pop at count=2: count stays 2, and the response routes to the oldest requester.
- Reset at count=3 then three ALU results: no rsp_valid, err_o=1. A following rst clears err_o to 0.
- clr at count=2: busy_o=0 next cycle, and the next grant goes to requester 0.
